// File: rtl/data_mem_io_pkg.sv
// Shared definitions for the CPU data-memory / MMIO block: the register map,
// the timer control bit positions and the address decoder used by the RTL.
package data_mem_io_pkg;

  localparam logic [31:0] ADDR_LED     = 32'hC000_0000;
  localparam logic [31:0] ADDR_SW      = 32'hC000_0004;
  localparam logic [31:0] ADDR_KEY     = 32'hC000_0008;
  localparam logic [31:0] ADDR_CYCLE   = 32'hC000_0010;
  localparam logic [31:0] ADDR_TCOUNT  = 32'hC000_0014;
  localparam logic [31:0] ADDR_TCTRL   = 32'hC000_0018;
  localparam logic [31:0] ADDR_TRELOAD = 32'hC000_001C;

  localparam int RAM_WORDS = 256;

  localparam int TCTRL_ENABLE  = 0;
  localparam int TCTRL_RELOAD  = 1;
  localparam int TCTRL_EXPIRED = 2;

  typedef enum logic [3:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_LED,
    REGION_SW,
    REGION_KEY,
    REGION_CYCLE,
    REGION_TCOUNT,
    REGION_TCTRL,
    REGION_TRELOAD
  } region_e;

  // Word-level decode: the byte offset within a word never affects the target.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    r = REGION_NONE;
    if (addr[31:10] == 22'd0)                r = REGION_RAM;
    else if (addr[31:2] == ADDR_LED[31:2])     r = REGION_LED;
    else if (addr[31:2] == ADDR_SW[31:2])      r = REGION_SW;
    else if (addr[31:2] == ADDR_KEY[31:2])     r = REGION_KEY;
    else if (addr[31:2] == ADDR_CYCLE[31:2])   r = REGION_CYCLE;
    else if (addr[31:2] == ADDR_TCOUNT[31:2])  r = REGION_TCOUNT;
    else if (addr[31:2] == ADDR_TCTRL[31:2])   r = REGION_TCTRL;
    else if (addr[31:2] == ADDR_TRELOAD[31:2]) r = REGION_TRELOAD;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_io_timer.sv
// Down-counting MMIO timer with optional auto-reload and a sticky expired flag
// that doubles as the interrupt line.
module mmio_timer
  import data_mem_io_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        wr_count,
  input  logic        wr_ctrl,
  input  logic        wr_reload,
  input  logic [31:0] wdata,
  output logic [31:0] tcount,
  output logic [31:0] treload,
  output logic [31:0] tctrl,
  output logic        irq
);

  logic enable;
  logic auto_reload;
  logic expired;
  logic fire;

  assign fire = enable && (tcount == 32'd1);

  // Counter, reload value and control bits; CPU stores to TCOUNT beat the
  // countdown, and a fresh expiry beats a same-cycle write-one-to-clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcount      <= 32'd0;
      treload     <= 32'd0;
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      expired     <= 1'b0;
    end else begin
      if (wr_count)
        tcount <= wdata;
      else if (enable && (tcount > 32'd1))
        tcount <= tcount - 32'd1;
      else if (fire)
        tcount <= auto_reload ? treload : 32'd0;

      if (wr_reload)
        treload <= wdata;

      if (wr_ctrl) begin
        enable      <= wdata[TCTRL_ENABLE];
        auto_reload <= wdata[TCTRL_RELOAD];
      end

      if (fire)
        expired <= 1'b1;
      else if (wr_ctrl && wdata[TCTRL_EXPIRED])
        expired <= 1'b0;
    end
  end

  // Read view of the control register with the unused bits tied low.
  always_comb begin
    tctrl                = 32'd0;
    tctrl[TCTRL_ENABLE]  = enable;
    tctrl[TCTRL_RELOAD]  = auto_reload;
    tctrl[TCTRL_EXPIRED] = expired;
  end

  assign irq = expired;

endmodule

// File: rtl/data_mem_io.sv
// CPU data port: 256-word RAM plus memory-mapped LEDs, switches, keys, a free
// running cycle counter and the timer. Loads are combinational from addr.
module data_mem_io
  import data_mem_io_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  led,
  output logic        irq
);

  region_e     region;
  logic [31:0] ram [RAM_WORDS];
  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic [3:0]  key_meta;
  logic [3:0]  key_sync;
  logic [31:0] cycle_count;
  logic [31:0] tcount;
  logic [31:0] treload;
  logic [31:0] tctrl;

  assign region = decode_region(addr);

  // Word RAM; deliberately not reset so contents survive a CPU reset.
  always_ff @(posedge clock) begin
    if (we && (region == REGION_RAM))
      ram[addr[9:2]] <= datain;
  end

  // Board input synchronizers, the cycle counter and the LED register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_meta     <= 10'd0;
      sw_sync     <= 10'd0;
      key_meta    <= 4'd0;
      key_sync    <= 4'd0;
      cycle_count <= 32'd0;
      led         <= 10'd0;
    end else begin
      sw_meta     <= sw;
      sw_sync     <= sw_meta;
      key_meta    <= key;
      key_sync    <= key_meta;
      cycle_count <= cycle_count + 32'd1;
      if (we && (region == REGION_LED))
        led <= datain[9:0];
    end
  end

  mmio_timer u_timer (
    .clock     (clock),
    .resetn    (resetn),
    .wr_count  (we && (region == REGION_TCOUNT)),
    .wr_ctrl   (we && (region == REGION_TCTRL)),
    .wr_reload (we && (region == REGION_TRELOAD)),
    .wdata     (datain),
    .tcount    (tcount),
    .treload   (treload),
    .tctrl     (tctrl),
    .irq       (irq)
  );

  // Load mux; keys are presented active-high (1 = pressed).
  always_comb begin
    dataout = 32'd0;
    case (region)
      REGION_RAM:     dataout = ram[addr[9:2]];
      REGION_LED:     dataout = {22'd0, led};
      REGION_SW:      dataout = {22'd0, sw_sync};
      REGION_KEY:     dataout = {28'd0, ~key_sync};
      REGION_CYCLE:   dataout = cycle_count;
      REGION_TCOUNT:  dataout = tcount;
      REGION_TCTRL:   dataout = tctrl;
      REGION_TRELOAD: dataout = treload;
      default:        dataout = 32'd0;
    endcase
  end

endmodule
